// File: rtl/multicore_pkg.sv
// Shared fetch-stage types: instruction width, fetch FSM states, prefetch entry layout.
// Latency: none (types and a pure helper only).
// Backpressure: not applicable.
package multicore_pkg;

    localparam int INST_SIZE = 32;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } t_fetch_state;

    typedef struct packed {
        logic [INST_SIZE-1:0] inst;
        logic [INST_SIZE-1:0] pc;
    } t_fetch_entry;

    // Clear the byte offset so every fetch address is word aligned.
    function automatic logic [INST_SIZE-1:0] word_align(input logic [INST_SIZE-1:0] addr);
        return {addr[INST_SIZE-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/response bus between the fetch unit and the memory.
// Latency: wires only; responses return strictly in request order.
// Backpressure: request held until gnt; responses are never stalled.
interface instr_fetch_unit_if;
    import multicore_pkg::*;

    logic                 imem_req;
    logic [INST_SIZE-1:0] imem_addr;
    logic                 imem_gnt;
    logic                 imem_rvalid;
    logic [INST_SIZE-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {inst, pc} entries returned from instruction memory.
// Latency: push visible at head one cycle later; pop and flush take effect at the clock edge.
// Backpressure: none internally; the caller's request credit guarantees no overflow.
module fetch_fifo
    import multicore_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   i_aclk,
    input  logic                   i_reset,
    input  logic                   push,
    input  t_fetch_entry           push_dat,
    input  logic                   pop,
    input  logic                   flush,
    output t_fetch_entry           head_dat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    t_fetch_entry  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;

    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign head_dat = mem[rd_ptr];

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge i_aclk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy tracking; flush empties the queue in one cycle.
    always_ff @(posedge i_aclk) begin
        if (i_reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: issues in-order imem requests, buffers responses, presents {inst, pc, pc+4} to decode.
// Latency: o_valid one cycle after the matching rvalid; redirects flush and retarget in one cycle.
// Backpressure: i_stall holds the head; request credit (outstanding + buffered < FIFO_DEPTH) throttles imem.
// Optional FETCH_STATS_EN adds saturating redirect and stall counters.
module instr_fetch_unit
    import multicore_pkg::*;
#(
    parameter logic [INST_SIZE-1:0] RESET_PC   = '0,
    parameter int                   FIFO_DEPTH = 2
) (
    input  logic                  i_aclk,
    input  logic                  i_reset,
    input  logic                  i_exe_redirect,
    input  logic [INST_SIZE-1:0]  i_exe_addr,
    input  logic                  i_dec_redirect,
    input  logic [INST_SIZE-1:0]  i_dec_addr,
    input  logic                  i_stall,
    instr_fetch_unit_if.master    imem,
    output logic                  o_valid,
    output logic [INST_SIZE-1:0]  o_inst,
    output logic [INST_SIZE-1:0]  o_pc,
    output logic [INST_SIZE-1:0]  o_pcplus4
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]           o_redirect_cnt,
    output logic [31:0]           o_stall_cnt
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    t_fetch_state         state_q;
    t_fetch_state         state_d;
    logic [INST_SIZE-1:0] pc_q;
    logic [INST_SIZE-1:0] rsp_pc_q;
    logic [CW-1:0]        outstanding_q;
    logic [CW-1:0]        outstanding_d;
    logic [CW-1:0]        drop_q;
    logic [CW-1:0]        drop_d;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_empty;
    logic                 redirect;
    logic [INST_SIZE-1:0] redirect_pc;
    logic                 credit_ok;
    logic                 gnt_fire;
    logic                 rsp_keep;
    logic                 pop;
    t_fetch_entry         head;
    t_fetch_entry         push_entry;

    // Execute is the older instruction, so its redirect wins over decode's.
    assign redirect    = i_exe_redirect | i_dec_redirect;
    assign redirect_pc = word_align(i_exe_redirect ? i_exe_addr : i_dec_addr);

    assign credit_ok     = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
    assign imem.imem_req  = ~i_reset & (state_q == RUN) & credit_ok;
    assign imem.imem_addr = pc_q;
    assign gnt_fire       = imem.imem_req & imem.imem_gnt;

    // A response is kept only when nothing older is pending discard and no redirect kills it.
    assign rsp_keep   = imem.imem_rvalid & (drop_q == '0) & ~redirect;
    assign push_entry = '{inst: imem.imem_rdata, pc: rsp_pc_q};
    assign pop        = o_valid & ~i_stall & ~redirect;

    assign o_valid   = ~fifo_empty;
    assign o_inst    = head.inst;
    assign o_pc      = head.pc;
    assign o_pcplus4 = head.pc + INST_SIZE'(4);

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_aclk   (i_aclk),
        .i_reset  (i_reset),
        .push     (rsp_keep),
        .push_dat (push_entry),
        .pop      (pop),
        .flush    (redirect),
        .head_dat (head),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

    // In-flight accounting; on redirect every request still in flight (incl. this cycle's grant) becomes a drop.
    always_comb begin
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        case ({gnt_fire, imem.imem_rvalid})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
        if (redirect) begin
            drop_d = outstanding_d;
        end else if (imem.imem_rvalid && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
        end
    end

    // Fetch FSM next state: stay in FLUSH while stale responses remain to be discarded.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (redirect && (drop_d != '0)) state_d = FLUSH;
            FLUSH:   if (drop_d == '0)               state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Fetch FSM state register.
    always_ff @(posedge i_aclk) begin
        if (i_reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Request PC, response PC tracker and credit counters.
    always_ff @(posedge i_aclk) begin
        if (i_reset) begin
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            if (redirect) begin
                pc_q     <= redirect_pc;
                rsp_pc_q <= redirect_pc;
            end else begin
                if (gnt_fire) pc_q     <= pc_q + INST_SIZE'(4);
                if (rsp_keep) rsp_pc_q <= rsp_pc_q + INST_SIZE'(4);
            end
        end
    end

`ifdef FETCH_STATS_EN
    // Saturating event counters for redirect cycles and stalled-valid cycles.
    always_ff @(posedge i_aclk) begin
        if (i_reset) begin
            o_redirect_cnt <= '0;
            o_stall_cnt    <= '0;
        end else begin
            if (redirect && (o_redirect_cnt != '1)) o_redirect_cnt <= o_redirect_cnt + 1'b1;
            if (o_valid && i_stall && (o_stall_cnt != '1)) o_stall_cnt <= o_stall_cnt + 1'b1;
        end
    end
`endif

endmodule
